// File: rtl/multiport_regfile.sv
// multiport_regfile: NREGS x XLEN register file, NRD combinational read
// ports, one write port, entry 0 hardwired to zero.
// After reset the array is swept to zero (entries 1..NREGS-1, one per cycle)
// before ready rises; reads return 0 and writes are dropped until then.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   raddr[NRD*AW]         read addresses, lane i at [i*AW +: AW]
//   rdata[NRD*XLEN]       read data, lane i at [i*XLEN +: XLEN]
//   we, waddr, wdata      write port (takes effect on the rising edge)
//   ready                 high once the clear sweep has finished

module multiport_regfile_lane #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 1
) (
  input  logic [NREGS-1:0][XLEN-1:0] mem,
  input  logic                       run,
  input  logic [AW-1:0]              raddr,
  input  logic                       wen,   // qualified write: RUN, we, waddr != 0
  input  logic [AW-1:0]              waddr,
  input  logic [XLEN-1:0]            wdata,
  output logic [XLEN-1:0]            rdata
);
  always_comb begin
    rdata = '0;
    if (run && raddr != '0) begin
      rdata = mem[raddr];
      // wen already excludes address 0, so x0 never forwards
      if (BYPASS != 0 && wen && raddr == waddr) rdata = wdata;
    end
  end
endmodule

module multiport_regfile #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NRD*$clog2(NREGS)-1:0]    raddr,
  output logic [NRD*XLEN-1:0]             rdata,
  input  logic                            we,
  input  logic [$clog2(NREGS)-1:0]        waddr,
  input  logic [XLEN-1:0]                 wdata,
  output logic                            ready
);
  localparam int AW = $clog2(NREGS);
  localparam logic [AW-1:0] LAST = AW'(NREGS-1);

  typedef enum logic [0:0] {CLEAR, RUN} state_t;

  typedef struct packed {
    logic            en;
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } wreq_t;

  state_t                     state;
  logic [AW-1:0]              clr_idx;
  logic [NREGS-1:0][XLEN-1:0] mem;   // entry 0 is never written nor read
  logic                       run;
  wreq_t                      wr;

  assign run     = (state == RUN);
  assign wr.en   = run && we && (waddr != '0);
  assign wr.addr = waddr;
  assign wr.data = wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_idx <= AW'(1);
      ready   <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          mem[clr_idx] <= '0;
          if (clr_idx == LAST) begin
            state <= RUN;
            ready <= 1'b1;
          end else begin
            clr_idx <= clr_idx + 1'b1;
          end
        end
        RUN: begin
          if (wr.en) mem[wr.addr] <= wr.data;
        end
        default: state <= CLEAR;
      endcase
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_lane
    multiport_regfile_lane #(
      .XLEN(XLEN), .NREGS(NREGS), .AW(AW), .BYPASS(BYPASS)
    ) u_lane (
      .mem   (mem),
      .run   (run),
      .raddr (raddr[i*AW +: AW]),
      .wen   (wr.en),
      .waddr (wr.addr),
      .wdata (wr.data),
      .rdata (rdata[i*XLEN +: XLEN])
    );
  end
endmodule

// File: doc/multiport_regfile.md
MULTIPORT_REGFILE -- requirements
Module: multiport_regfile

Interface
REQ-001 SHALL have parameter XLEN, default 32: data width in bits.
REQ-002 SHALL have parameter NREGS, default 32: register count; a power of two, at least 4.
REQ-003 SHALL have parameter NRD, default 2: number of read ports, 1..4.
REQ-004 SHALL have parameter BYPASS, default 1: 1 enables write-to-read forwarding, 0 disables it.
REQ-005 SHALL derive localparam AW = log2(NREGS) and expose it on no port.
REQ-006 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port raddr, input, NRD*AW bits: read addresses; port i occupies bits [i*AW +: AW].
REQ-009 SHALL have port rdata, output, NRD*XLEN bits: read data; port i occupies bits [i*XLEN +: XLEN].
REQ-010 SHALL have port we, input, 1 bit: write enable.
REQ-011 SHALL have port waddr, input, AW bits: write address.
REQ-012 SHALL have port wdata, input, XLEN bits: write data.
REQ-013 SHALL have port ready, output, 1 bit: high when the clear sequence is complete and the array is usable.

Function
REQ-014 SHALL implement a two-state FSM with states CLEAR and RUN.
REQ-015 SHALL, in CLEAR, write zero to entry clr_idx each cycle, with clr_idx counting 1..NREGS-1; it SHALL enter RUN on the cycle after clr_idx = NREGS-1 is written.
REQ-016 SHALL drive ready = 1 only in RUN.
REQ-017 SHALL ignore we in CLEAR; no user write may reach the array during CLEAR.
REQ-018 SHALL drive every rdata lane to 0 while in CLEAR.
REQ-019 SHALL, in RUN, perform a write at the rising edge when we = 1 and waddr != 0; the written value is visible through the array on the next cycle.
REQ-020 SHALL treat entry 0 as hardwired zero: reads of address 0 return 0 and writes to address 0 are discarded, including with bypass.
REQ-021 SHALL make reads combinational: lane i = array[raddr_i] in the same cycle.
REQ-022 SHALL, when BYPASS = 1, in RUN, with we = 1, waddr != 0 and raddr_i = waddr, return wdata on lane i in the same cycle.
REQ-023 SHALL, when BYPASS = 0, return the old array contents in the REQ-022 case.
REQ-024 SHALL resolve each lane independently; several lanes may read the same address, and all of them receive the same value, forwarded or not.
REQ-025 SHALL never let a write affect any entry other than waddr.
REQ-026 SHALL not clear entry 0 storage in the FSM, since it is never read.

Reset
REQ-027 SHALL, when rst = 1 at a rising edge, go to CLEAR, set clr_idx = 1 and drive ready = 0 from the next cycle; this applies in any state, including mid-CLEAR, which restarts the sweep.
REQ-028 SHALL hold ready low and all rdata lanes at 0 while rst is held high.
REQ-029 SHALL deassert ready for exactly NREGS-1 cycles after rst falls; the CLEAR duration is NREGS-1 cycles, then RUN.
REQ-030 SHALL have no asynchronous logic; no reset input other than rst.

Verification
REQ-031 SHALL cover reset and clear: with defaults, pulse rst for 1 cycle and count cycles -> ready stays 0 for 31 cycles, then 1; all lanes read 0 afterwards for addresses 0..31.
REQ-032 SHALL cover write then read: in RUN, write 0xDEADBEEF to address 5, BYPASS = 0 -> lane 0 reads the old value 0 in the write cycle and 0xDEADBEEF the next cycle.
REQ-033 SHALL cover forwarding: BYPASS = 1, we = 1, waddr = 7, wdata = 0x12345678, raddr0 = raddr1 = 7 -> both lanes show 0x12345678 in the same cycle.
REQ-034 SHALL cover x0: write 0xFFFFFFFF to address 0 with raddr0 = 0 -> lane reads 0 in the same cycle and the next cycle.
REQ-035 SHALL cover reset mid-clear: assert rst at clear cycle 10 -> ready stays low for a full 31 cycles after rst falls; a write attempted during CLEAR to address 3 leaves entry 3 at 0.
REQ-036 SHALL cover parameter sweep: run with NREGS = 16, NRD = 4, XLEN = 64 -> CLEAR lasts 15 cycles; 4 independent lanes match a reference model over 10k random writes and reads.
